param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file.sv | 84 ++++++++
 tb/tb_param_reg_file.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_reg_file.sv
// param_reg_file: 2-read/1-write register file that zeroes itself with a sweep after reset or on request.
// Define RF_BYPASS_EN to forward an accepted write to a matching read port in the same cycle.
module param_reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int ZERO_REG = 0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [ADDR_W-1:0] in_rd_a_add,
    input  logic [ADDR_W-1:0] in_rd_b_add,
    output logic [DATA_W-1:0] out_rd_a_val,
    output logic [DATA_W-1:0] out_rd_b_val,
    input  logic [ADDR_W-1:0] in_wr_add,
    input  logic [DATA_W-1:0] in_wr_val,
    input  logic              in_wr_en,
    input  logic              in_clr,
    output logic              out_busy,
    output logic              out_wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              busy_q, busy_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_val;
    logic              wr_ok;

    always_comb begin
        wr_ok     = state_q == IDLE && in_wr_en && !in_clr && !(ZERO_REG != 0 && in_wr_add == '0);
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == '1) state_d = IDLE;
        end else if (in_clr) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end
        busy_d    = state_d == CLEAR;
        wr_drop_d = in_wr_en && (state_q == CLEAR || in_clr);
        // The sweep owns the single write port; user writes only land in IDLE
        mem_we    = state_q == CLEAR || wr_ok;
        mem_add   = state_q == CLEAR ? clr_idx_q : in_wr_add;
        mem_val   = state_q == CLEAR ? '0 : in_wr_val;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Contents are deliberately not reset; the sweep zeroes them
    always_ff @(posedge in_clk) begin
        if (mem_we) mem_q[mem_add] <= mem_val;
    end

    always_comb begin
        out_rd_a_val = busy_q || (ZERO_REG != 0 && in_rd_a_add == '0) ? '0 : mem_q[in_rd_a_add];
        out_rd_b_val = busy_q || (ZERO_REG != 0 && in_rd_b_add == '0) ? '0 : mem_q[in_rd_b_add];
`ifdef RF_BYPASS_EN
        if (wr_ok && in_wr_add == in_rd_a_add) out_rd_a_val = in_wr_val;
        if (wr_ok && in_wr_add == in_rd_b_add) out_rd_b_val = in_wr_val;
`endif
    end

    assign out_busy    = busy_q;
    assign out_wr_drop = wr_drop_q;
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: scoreboard bench for param_reg_file (defaults, plus a ZERO_REG=1 copy on the same stimulus).
module tb_param_reg_file;
    logic        clk = 0, rst = 0, wr_en = 0, clr = 0;
    logic [7:0]  rd_a = 0, rd_b = 0, wr_add = 0;
    logic [15:0] wr_val = 0;
    logic [15:0] a, b, za, zb;
    logic        busy, drop, zbusy, zdrop;
    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    logic [15:0] e;
    int          n_cmp = 0, n_err = 0, n;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1;
`else
    localparam bit BYP = 0;
`endif

    param_reg_file dut (
        .in_clk(clk), .in_rst(rst), .in_rd_a_add(rd_a), .in_rd_b_add(rd_b),
        .out_rd_a_val(a), .out_rd_b_val(b), .in_wr_add(wr_add), .in_wr_val(wr_val),
        .in_wr_en(wr_en), .in_clr(clr), .out_busy(busy), .out_wr_drop(drop)
    );

    param_reg_file #(.ZERO_REG(1)) dut_z (
        .in_clk(clk), .in_rst(rst), .in_rd_a_add(rd_a), .in_rd_b_add(rd_b),
        .out_rd_a_val(za), .out_rd_b_val(zb), .in_wr_add(wr_add), .in_wr_val(wr_val),
        .in_wr_en(wr_en), .in_clr(clr), .out_busy(zbusy), .out_wr_drop(zdrop)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
        $fatal(1);
    end

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) model[i] = '0;
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || drop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b drop=%b, required busy=1 drop=0", busy, drop);
        end
        @(negedge clk);
        rst = 1;
        #1;
        busy_len(n);
        n_cmp++;
        if (n !== 256) begin
            n_err++;
            $display("FAIL reset_sweep_len: busy cycles=%0d, required 256", n);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            rd_a = 8'(i);
            rd_b = 8'(255 - i);
            exp_q.push_back(model[rd_a]);
            exp_q.push_back(model[rd_b]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (a !== e) begin n_err++; $display("FAIL reset_read_a[%0d]: got %h, required %h", i, a, e); end
            e = exp_q.pop_front();
            n_cmp++;
            if (b !== e) begin n_err++; $display("FAIL reset_read_b[%0d]: got %h, required %h", 255 - i, b, e); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 1; wr_add = 8'h0A; wr_val = 16'hBEEF; rd_a = 8'h0A; rd_b = 8'h0A;
        exp_q.push_back(BYP ? 16'hBEEF : model[8'h0A]);
        exp_q.push_back(BYP ? 16'hBEEF : model[8'h0A]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL wr_cycle_a: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL wr_cycle_b: got %h, required %h", b, e); end
        model[8'h0A] = 16'hBEEF;
        @(negedge clk);
        wr_en = 0;
        exp_q.push_back(model[8'h0A]);
        exp_q.push_back(model[8'h0A]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL wr_next_a: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL wr_next_b: got %h, required %h", b, e); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        wr_en = 1; wr_add = 8'h05; wr_val = 16'h1234; rd_a = 8'h05; rd_b = 8'h0A;
        exp_q.push_back(BYP ? 16'h1234 : model[8'h05]);
        exp_q.push_back(model[8'h0A]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL same_cycle_a: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL same_cycle_other_b: got %h, required %h", b, e); end
        model[8'h05] = 16'h1234;
        @(negedge clk);
        wr_en = 0;
        exp_q.push_back(model[8'h05]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL same_cycle_after_a: got %h, required %h", a, e); end
    endtask

    task automatic test_full_range();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            wr_en = 1; wr_add = 8'(i); wr_val = 16'($urandom) | 16'h0001;
            model[i] = wr_val;
        end
        @(negedge clk);
        wr_en = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            rd_a = 8'(i);
            rd_b = 8'(i) ^ 8'hFF;
            exp_q.push_back(model[rd_a]);
            exp_q.push_back(model[rd_b]);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (a !== e) begin n_err++; $display("FAIL range_a[%0d]: got %h, required %h", rd_a, a, e); end
            e = exp_q.pop_front();
            n_cmp++;
            if (b !== e) begin n_err++; $display("FAIL range_b[%0d]: got %h, required %h", rd_b, b, e); end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en = 1; wr_add = 8'h00; wr_val = 16'h5555; rd_a = 8'h00; rd_b = 8'h01;
        model[0] = 16'h5555;
        @(negedge clk);
        wr_en = 0;
        #1;
        n_cmp++;
        if (a !== model[0]) begin n_err++; $display("FAIL zr_plain_a0: got %h, required %h", a, model[0]); end
        n_cmp++;
        if (za !== 16'h0000) begin n_err++; $display("FAIL zr_read0: got %h, required 0000", za); end
        n_cmp++;
        if (zb !== model[1]) begin n_err++; $display("FAIL zr_read1: got %h, required %h", zb, model[1]); end
        n_cmp++;
        if (zdrop !== 1'b0 || drop !== 1'b0) begin
            n_err++;
            $display("FAIL zr_no_drop: zdrop=%b drop=%b, required 0 0", zdrop, drop);
        end
    endtask

    task automatic test_drop_in_sweep();
        @(negedge clk);
        clr = 1; rd_a = 8'hFF; rd_b = 8'h20;
        @(negedge clk);
        clr = 0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || a !== 16'h0000 || b !== 16'h0000) begin
            n_err++;
            $display("FAIL sweep_forced_zero: busy=%b a=%h b=%h, required 1 0000 0000", busy, a, b);
        end
        repeat (9) @(negedge clk);
        wr_en = 1; wr_add = 8'h20; wr_val = 16'hAAAA;
        @(negedge clk);
        wr_en = 0;
        #1;
        n_cmp++;
        if (drop !== 1'b1) begin n_err++; $display("FAIL sweep_drop_pulse: got %b, required 1", drop); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (drop !== 1'b0) begin n_err++; $display("FAIL sweep_drop_one_cycle: got %b, required 0", drop); end
        busy_len(n);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_end: busy=%b after %0d cycles, required 0", busy, n); end
        for (int i = 0; i < 256; i++) model[i] = '0;
        @(negedge clk);
        rd_a = 8'h20; rd_b = 8'hFF;
        exp_q.push_back(model[8'h20]);
        exp_q.push_back(model[8'hFF]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL sweep_dropped_target: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL sweep_cleared_ff: got %h, required %h", b, e); end
    endtask

    task automatic test_clr_wins();
        @(negedge clk);
        wr_en = 1; wr_add = 8'h03; wr_val = 16'h00FF; rd_a = 8'h03; rd_b = 8'h04;
        model[3] = 16'h00FF;
        @(negedge clk);
        wr_add = 8'h04; wr_val = 16'h7777; clr = 1;
        exp_q.push_back(model[3]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL clr_pre_read3: got %h, required %h", a, e); end
        @(negedge clk);
        wr_en = 0; clr = 0;
        #1;
        n_cmp++;
        if (drop !== 1'b1) begin n_err++; $display("FAIL clr_wins_drop: got %b, required 1", drop); end
        busy_len(n);
        n_cmp++;
        if (n !== 256) begin n_err++; $display("FAIL clr_sweep_len: busy cycles=%0d, required 256", n); end
        for (int i = 0; i < 256; i++) model[i] = '0;
        exp_q.push_back(model[3]);
        exp_q.push_back(model[4]);
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL clr_read3: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL clr_read4: got %h, required %h", b, e); end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        wr_en = 1; wr_add = 8'h40; wr_val = 16'h4242;
        @(negedge clk);
        wr_en = 0; clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (99) @(negedge clk);
        wr_en = 1; wr_add = 8'h41; wr_val = 16'h1111;
        rst = 0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || drop !== 1'b0) begin
            n_err++;
            $display("FAIL midsweep_reset_flags: busy=%b drop=%b, required 1 0", busy, drop);
        end
        repeat (3) @(negedge clk);
        wr_en = 0;
        rst = 1;
        #1;
        busy_len(n);
        n_cmp++;
        if (n !== 256) begin n_err++; $display("FAIL midsweep_restart_len: busy cycles=%0d, required 256", n); end
        rd_a = 8'h40; rd_b = 8'h41;
        exp_q.push_back(model[8'h40]);
        exp_q.push_back(model[8'h41]);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL midsweep_read40: got %h, required %h", a, e); end
        e = exp_q.pop_front();
        n_cmp++;
        if (b !== e) begin n_err++; $display("FAIL midsweep_read41: got %h, required %h", b, e); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_full_range();
        test_zero_reg();
        test_drop_in_sweep();
        test_clr_wins();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
